// File: rtl/pulse_conditioner.sv
// rtl/pulse_conditioner.sv - debounced, qualified one-shot conditioner for an external trigger
//
// Purpose:
//   Synchronizes an asynchronous trigger and accepts it only after it has been
//   seen high for FILTER_LEN consecutive synchronized samples. Each accepted
//   pulse produces one registered strobe, followed by a dead time of
//   HOLDOFF_LEN clocks and a wait for the trigger to return low. Accepted and
//   rejected (too short) pulses are counted.
//
// Ports:
//   system_clock      in   single clock, rising edge
//   external_reset_n  in   asynchronous active-low reset, released synchronously
//   enable            in   conditioning enable; low forces IDLE with no strobe
//   raw_pulse         in   unsynchronized external trigger
//   counter_clear     in   synchronous clear of both counters (wins over increments)
//   clean_pulse       out  one-cycle registered strobe per accepted pulse
//   busy              out  high whenever the FSM is not in IDLE
//   pulse_count       out  accepted pulses, wraps
//   rejected_count    out  filter rejections, saturates

module pulse_conditioner #(
  parameter int FILTER_LEN  = 4,
  parameter int HOLDOFF_LEN = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   system_clock,
  input  logic                   external_reset_n,
  input  logic                   enable,
  input  logic                   raw_pulse,
  input  logic                   counter_clear,
  output logic                   clean_pulse,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pulse_count,
  output logic [COUNT_WIDTH-1:0] rejected_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [7:0]  FILT_TGT  = 8'(FILTER_LEN);
  localparam logic [15:0] HOLD_LAST = (HOLDOFF_LEN > 0) ? 16'(HOLDOFF_LEN - 1) : 16'd0;
  // With no dead time the FSM skips HOLDOFF entirely.
  localparam state_t      POST_ACCEPT = (HOLDOFF_LEN == 0) ? WAIT_LOW : HOLDOFF;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            state_next;
  logic              sync_meta;
  logic              sync_level;
  logic              run;
  logic [7:0]        filt_cnt;
  logic [7:0]        filt_next;
  logic [15:0]       hold_cnt;
  logic [15:0]       hold_next;
  logic              accept;
  logic              reject;
  logic              strobe_next;

  // Two-flop synchronizer for the trigger, plus a release flag: reset is
  // released on the first edge after deassertion, so FSM decisions begin on
  // the second edge and never race the asynchronous release.
  always_ff @(posedge system_clock or negedge external_reset_n) begin
    if (!external_reset_n) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      run        <= 1'b0;
    end else begin
      sync_meta  <= raw_pulse;
      sync_level <= sync_meta;
      run        <= 1'b1;
    end
  end

  // State register, working counters and the registered strobe.
  always_ff @(posedge system_clock or negedge external_reset_n) begin
    if (!external_reset_n) begin
      state       <= IDLE;
      filt_cnt    <= 8'd0;
      hold_cnt    <= 16'd0;
      clean_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      filt_cnt    <= filt_next;
      hold_cnt    <= hold_next;
      clean_pulse <= strobe_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    filt_next  = filt_cnt;
    hold_next  = hold_cnt;
    accept     = 1'b0;
    reject     = 1'b0;
    if (!run || !enable) begin
      // Disable abandons any activity silently: no strobe, no rejection.
      state_next = IDLE;
      filt_next  = 8'd0;
      hold_next  = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_level) begin
            if (FILTER_LEN == 1) begin
              accept     = 1'b1;
              state_next = POST_ACCEPT;
              filt_next  = 8'd0;
            end else begin
              state_next = QUALIFY;
              filt_next  = 8'd1;
            end
          end
        end
        QUALIFY: begin
          if (!sync_level) begin
            reject     = 1'b1;
            state_next = IDLE;
            filt_next  = 8'd0;
          end else if (filt_cnt + 8'd1 == FILT_TGT) begin
            accept     = 1'b1;
            state_next = POST_ACCEPT;
            filt_next  = 8'd0;
          end else begin
            filt_next = filt_cnt + 8'd1;
          end
        end
        HOLDOFF: begin
          // hold_cnt enters at 0, so the state lasts exactly HOLDOFF_LEN cycles.
          if (hold_cnt == HOLD_LAST) begin
            state_next = WAIT_LOW;
            hold_next  = 16'd0;
          end else begin
            hold_next = hold_cnt + 16'd1;
          end
        end
        WAIT_LOW: begin
          if (!sync_level) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          filt_next  = 8'd0;
          hold_next  = 16'd0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy        = (state != IDLE);
    strobe_next = accept;
  end

  // Event counters: clear has priority over any increment in the same cycle.
  always_ff @(posedge system_clock or negedge external_reset_n) begin
    if (!external_reset_n) begin
      pulse_count    <= '0;
      rejected_count <= '0;
    end else if (counter_clear) begin
      pulse_count    <= '0;
      rejected_count <= '0;
    end else begin
      if (accept) begin
        pulse_count <= pulse_count + 1'b1;
      end
      if (reject && (rejected_count != CNT_MAX)) begin
        rejected_count <= rejected_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// tb/tb_pulse_conditioner.sv - self-checking bench for pulse_conditioner

module tb_pulse_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        raw = 1'b0;
  logic        clr = 1'b0;

  logic        clean0, busy0, clean1, busy1, clean2, busy2;
  logic [15:0] pc0, rc0, pc2, rc2;
  logic [7:0]  pc1, rc1;

  always #5 clk = ~clk;

  // d0: default configuration; d1: short filter, no holdoff, narrow counters;
  // d2: single-sample filter with a short holdoff.
  pulse_conditioner #(.FILTER_LEN(4), .HOLDOFF_LEN(16), .COUNT_WIDTH(16)) d0 (
    .system_clock(clk), .external_reset_n(rst_n), .enable(enable), .raw_pulse(raw),
    .counter_clear(clr), .clean_pulse(clean0), .busy(busy0), .pulse_count(pc0),
    .rejected_count(rc0));
  pulse_conditioner #(.FILTER_LEN(2), .HOLDOFF_LEN(0), .COUNT_WIDTH(8)) d1 (
    .system_clock(clk), .external_reset_n(rst_n), .enable(enable), .raw_pulse(raw),
    .counter_clear(clr), .clean_pulse(clean1), .busy(busy1), .pulse_count(pc1),
    .rejected_count(rc1));
  pulse_conditioner #(.FILTER_LEN(1), .HOLDOFF_LEN(3), .COUNT_WIDTH(16)) d2 (
    .system_clock(clk), .external_reset_n(rst_n), .enable(enable), .raw_pulse(raw),
    .counter_clear(clr), .clean_pulse(clean2), .busy(busy2), .pulse_count(pc2),
    .rejected_count(rc2));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a pulse is a streak of high synchronized samples;
  // after acceptance there is a dead time, then the level must drop once.
  bit m1, m2, mrun;
  int streak[3], dead[3], pcm[3], rcm[3];
  bit need_low[3], ex_clean[3];

  task automatic model_reset();
    m1 = 0; m2 = 0; mrun = 0;
    for (int i = 0; i < 3; i++) begin
      streak[i] = 0; dead[i] = 0; need_low[i] = 0; pcm[i] = 0; rcm[i] = 0; ex_clean[i] = 0;
    end
  endtask

  task automatic step(input int i, input int f, input int h, input int w,
                      input bit s, input bit go);
    bit acc, rej;
    int mx;
    acc = 0; rej = 0;
    mx = (1 << w) - 1;
    if (go) begin
      if (!enable) begin
        streak[i] = 0; dead[i] = 0; need_low[i] = 0;
      end else if (dead[i] > 0) begin
        dead[i]--;
      end else if (need_low[i]) begin
        if (!s) need_low[i] = 0;
      end else if (s) begin
        streak[i]++;
        if (streak[i] >= f) begin
          acc = 1; streak[i] = 0; dead[i] = h; need_low[i] = 1;
        end
      end else if (streak[i] > 0) begin
        rej = 1; streak[i] = 0;
      end
    end
    if (clr) begin
      pcm[i] = 0; rcm[i] = 0;
    end else begin
      if (acc) pcm[i] = (pcm[i] + 1) & mx;
      if (rej && rcm[i] < mx) rcm[i]++;
    end
    ex_clean[i] = acc;
  endtask

  function automatic bit ex_busy(input int i);
    return (streak[i] > 0) || (dead[i] > 0) || need_low[i];
  endfunction

  task automatic model_edge();
    bit s, go;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m2; m2 = m1; m1 = raw;
    go = mrun; mrun = 1;
    step(0, 4, 16, 16, s, go);
    step(1, 2, 0, 8, s, go);
    step(2, 1, 3, 16, s, go);
  endtask

  task automatic compare_all();
    check("clean0", clean0, ex_clean[0]); check("busy0", busy0, ex_busy(0));
    check("pc0", pc0, pcm[0]);            check("rc0", rc0, rcm[0]);
    check("clean1", clean1, ex_clean[1]); check("busy1", busy1, ex_busy(1));
    check("pc1", pc1, pcm[1]);            check("rc1", rc1, rcm[1]);
    check("clean2", clean2, ex_clean[2]); check("busy2", busy2, ex_busy(2));
    check("pc2", pc2, pcm[2]);            check("rc2", rc2, rcm[2]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    int width;
    bit en;
    int n0;
    int first0;
    int rej0;
    int n2;
  } vec_t;

  vec_t tbl[7];
  int n0, first0, n2, left;

  initial begin
    tbl[0] = '{10, 1'b1, 1, 5, 0, 1};
    tbl[1] = '{3, 1'b1, 0, -1, 1, 1};
    tbl[2] = '{4, 1'b1, 1, 5, 0, 1};
    tbl[3] = '{1, 1'b1, 0, -1, 1, 1};
    tbl[4] = '{100, 1'b1, 1, 5, 0, 1};
    tbl[5] = '{5, 1'b0, 0, -1, 0, 0};
    tbl[6] = '{25, 1'b1, 1, 5, 0, 1};

    // Reset state.
    model_reset();
    #1;
    check("rst_clean0", clean0, 0); check("rst_busy0", busy0, 0);
    check("rst_pc0", pc0, 0);       check("rst_rc0", rc0, 0);
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Table-driven single pulses against default configuration.
    for (int t = 0; t < 7; t++) begin
      clr = 1'b1; cycle(); clr = 1'b0;
      enable = tbl[t].en;
      n0 = 0; first0 = -1; n2 = 0;
      for (int j = 0; j < tbl[t].width + 30; j++) begin
        raw = (j < tbl[t].width);
        cycle();
        if (clean0) begin
          n0++;
          if (first0 < 0) first0 = j;
        end
        if (clean2) n2++;
      end
      enable = 1'b1;
      check("tbl_strobes0", n0, tbl[t].n0);
      check("tbl_latency0", first0, tbl[t].first0);
      check("tbl_pc0", pc0, tbl[t].n0);
      check("tbl_rc0", rc0, tbl[t].rej0);
      check("tbl_idle0", busy0, 0);
      check("tbl_strobes2", n2, tbl[t].n2);
    end

    // Long level yields one strobe; a second pulse shortly after the fall is accepted.
    clr = 1'b1; cycle(); clr = 1'b0;
    n0 = 0;
    for (int j = 0; j < 145; j++) begin
      raw = (j < 100) || (j >= 105 && j < 115);
      cycle();
      if (clean0) n0++;
    end
    check("long_strobes0", n0, 2);
    check("long_pc0", pc0, 2);

    // Enable dropped during qualification.
    clr = 1'b1; cycle(); clr = 1'b0;
    raw = 1'b1;
    for (int j = 0; j < 3; j++) cycle();
    enable = 1'b0;
    cycle();
    check("dis_busy0", busy0, 0); check("dis_pc0", pc0, 0);
    check("dis_rc0", rc0, 0);     check("dis_clean0", clean0, 0);
    raw = 1'b0;
    for (int j = 0; j < 4; j++) cycle();
    enable = 1'b1;
    for (int j = 0; j < 4; j++) cycle();
    check("dis_rc0_after", rc0, 0);

    // Counter clear coincident with the strobe.
    for (int j = 0; j < 40; j++) begin
      raw = (j < 10);
      clr = (j == 5);
      cycle();
      if (j == 5) begin
        check("clr_strobe0", clean0, 1);
        check("clr_pc0", pc0, 0);
      end
    end
    clr = 1'b0;

    // Reset pulsed during holdoff, then a normal pulse after release.
    raw = 1'b1;
    for (int j = 0; j < 8; j++) cycle();
    rst_n = 1'b0;
    raw = 1'b0;
    #1;
    model_reset();
    check("rsth_clean0", clean0, 0); check("rsth_busy0", busy0, 0);
    check("rsth_pc0", pc0, 0);       check("rsth_rc0", rc0, 0);
    check("rsth_busy2", busy2, 0);   check("rsth_pc2", pc2, 0);
    for (int j = 0; j < 3; j++) cycle();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) cycle();
    first0 = -1;
    for (int j = 0; j < 40; j++) begin
      raw = (j < 10);
      cycle();
      if (clean0 && first0 < 0) first0 = j;
    end
    check("rsth_latency0", first0, 5);
    check("rsth_pc0_after", pc0, 1);

    // Accepted-pulse wrap on the 8-bit instance.
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int p = 0; p < 255; p++) begin
      raw = 1'b1; cycle(); cycle();
      raw = 1'b0; cycle(); cycle(); cycle();
    end
    check("wrap_pc1_max", pc1, 255);
    raw = 1'b1; cycle(); cycle();
    raw = 1'b0;
    for (int j = 0; j < 5; j++) cycle();
    check("wrap_pc1_zero", pc1, 0);

    // Rejection saturation with one-cycle glitches.
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int g = 0; g < 300; g++) begin
      raw = 1'b1; cycle();
      raw = 1'b0; cycle();
    end
    for (int j = 0; j < 5; j++) cycle();
    check("sat_rc1", rc1, 255);
    check("sat_pc1", pc1, 0);

    // Randomized traffic checked cycle by cycle against the model.
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (left == 0) begin
        raw = ~raw;
        left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 60))
                                           : int'($urandom_range(1, 8));
      end
      left--;
      enable = ($urandom_range(0, 39) != 0);
      clr = ($urandom_range(0, 59) == 0);
      rst_n = !(c >= 1500 && c < 1502);
      cycle();
    end
    rst_n = 1'b1;
    clr = 1'b0;
    raw = 1'b0;
    enable = 1'b1;
    for (int j = 0; j < 30; j++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
